// File: rtl/hazard_stage_tracker_if.sv
// rtl/hazard_stage_tracker_if.sv - ID-side fields, flush and per-stage tracking outputs
interface hazard_stage_tracker_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] id_rd_addr;
  logic              id_wr_en;
  logic              id_mem_rd;
  logic [REG_AW-1:0] id_rs1_addr;
  logic [REG_AW-1:0] id_rs2_addr;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic              flush;

  logic [REG_AW-1:0] ex_rd_addr;
  logic [REG_AW-1:0] mem_rd_addr;
  logic [REG_AW-1:0] wb_rd_addr;
  logic              ex_wr_en;
  logic              mem_wr_en;
  logic              wb_wr_en;
  logic              ex_mem_rd;
  logic              stall;

  modport master (
    output id_rd_addr, id_wr_en, id_mem_rd, id_rs1_addr, id_rs2_addr,
           id_rs1_used, id_rs2_used, flush,
    input  ex_rd_addr, mem_rd_addr, wb_rd_addr, ex_wr_en, mem_wr_en,
           wb_wr_en, ex_mem_rd, stall
  );

  modport slave (
    input  id_rd_addr, id_wr_en, id_mem_rd, id_rs1_addr, id_rs2_addr,
           id_rs1_used, id_rs2_used, flush,
    output ex_rd_addr, mem_rd_addr, wb_rd_addr, ex_wr_en, mem_wr_en,
           wb_wr_en, ex_mem_rd, stall
  );
endinterface

// File: rtl/hazard_stage_tracker.sv
// rtl/hazard_stage_tracker.sv - EX/MEM/WB destination tracking, load-use stall and flush control
module hazard_stage_tracker #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_stage_tracker_if.slave pif,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     stall_count
);

  logic [REG_AW-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
  logic              ex_we_q, mem_we_q, wb_we_q;
  logic              ex_ld_q;
  logic              load_use;
  logic              stall_int;
  logic [CNT_W-1:0]  cnt_q;

  // Only a load still in EX is uncoverable; once it reaches MEM the forwarding unit has the data.
  always_comb begin
    load_use = 1'b0;
    if (ex_ld_q && ex_we_q && (ex_rd_q != '0)) begin
      load_use = (pif.id_rs1_used && (pif.id_rs1_addr == ex_rd_q)) ||
                 (pif.id_rs2_used && (pif.id_rs2_addr == ex_rd_q));
    end
  end

  // A flushed consumer is killed anyway, so it never needs to wait.
  assign stall_int = load_use && !pif.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd_q  <= '0;
      ex_we_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      mem_rd_q <= '0;
      mem_we_q <= 1'b0;
      wb_rd_q  <= '0;
      wb_we_q  <= 1'b0;
    end else begin
      mem_rd_q <= ex_rd_q;
      mem_we_q <= ex_we_q;
      wb_rd_q  <= mem_rd_q;
      wb_we_q  <= mem_we_q;
      if (pif.flush || stall_int) begin
        ex_rd_q <= '0;
        ex_we_q <= 1'b0;
        ex_ld_q <= 1'b0;
      end else begin
        ex_rd_q <= pif.id_rd_addr;
        ex_we_q <= pif.id_wr_en && (pif.id_rd_addr != '0);
        ex_ld_q <= pif.id_mem_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (stall_int && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign pif.ex_rd_addr  = ex_rd_q;
  assign pif.mem_rd_addr = mem_rd_q;
  assign pif.wb_rd_addr  = wb_rd_q;
  assign pif.ex_wr_en    = ex_we_q;
  assign pif.mem_wr_en   = mem_we_q;
  assign pif.wb_wr_en    = wb_we_q;
  assign pif.ex_mem_rd   = ex_ld_q;
  assign pif.stall       = stall_int;
  assign stall_count     = cnt_q;

endmodule

// File: tb/tb_hazard_stage_tracker.sv
// tb/tb_hazard_stage_tracker.sv - randomized and directed checks of hazard_stage_tracker against a reference model
module tb_hazard_stage_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [15:0] cnt16;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  hazard_stage_tracker_if #(.REG_AW(5)) mif ();
  hazard_stage_tracker_if #(.REG_AW(5)) sif ();

  assign sif.id_rd_addr  = mif.id_rd_addr;
  assign sif.id_wr_en    = mif.id_wr_en;
  assign sif.id_mem_rd   = mif.id_mem_rd;
  assign sif.id_rs1_addr = mif.id_rs1_addr;
  assign sif.id_rs2_addr = mif.id_rs2_addr;
  assign sif.id_rs1_used = mif.id_rs1_used;
  assign sif.id_rs2_used = mif.id_rs2_used;
  assign sif.flush       = mif.flush;

  hazard_stage_tracker #(.REG_AW(5), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pif        (mif.slave),
    .cnt_clr    (cnt_clr),
    .stall_count(cnt16)
  );

  hazard_stage_tracker #(.REG_AW(5), .CNT_W(2)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .pif        (sif.slave),
    .cnt_clr    (cnt_clr),
    .stall_count(cnt2)
  );

  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } ent_t;

  ent_t pipe [3];
  int   m_cnt16;
  int   m_cnt2;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    m_cnt16 = 0;
    m_cnt2  = 0;
  endtask

  function automatic logic m_stall();
    logic hit;
    hit = (mif.id_rs1_used && mif.id_rs1_addr == pipe[0].rd) ||
          (mif.id_rs2_used && mif.id_rs2_addr == pipe[0].rd);
    return pipe[0].ld && pipe[0].we && (pipe[0].rd != 5'd0) && hit && !mif.flush;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".ex_rd"},  32'(mif.ex_rd_addr),  32'(pipe[0].rd));
    chk({tag, ".ex_we"},  32'(mif.ex_wr_en),    32'(pipe[0].we));
    chk({tag, ".ex_ld"},  32'(mif.ex_mem_rd),   32'(pipe[0].ld));
    chk({tag, ".mem_rd"}, 32'(mif.mem_rd_addr), 32'(pipe[1].rd));
    chk({tag, ".mem_we"}, 32'(mif.mem_wr_en),   32'(pipe[1].we));
    chk({tag, ".wb_rd"},  32'(mif.wb_rd_addr),  32'(pipe[2].rd));
    chk({tag, ".wb_we"},  32'(mif.wb_wr_en),    32'(pipe[2].we));
    chk({tag, ".cnt16"},  32'(cnt16),           32'(m_cnt16));
    chk({tag, ".cnt2"},   32'(cnt2),            32'(m_cnt2));
  endtask

  // One cycle: drive ID at the negedge, check stall, clock, advance the model, check stage outputs.
  task automatic step(input string tag, input logic [4:0] rd, input logic we, input logic ld,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                      input logic fl, input logic clr, output logic st);
    logic s;
    ent_t e;
    mif.id_rd_addr  = rd;
    mif.id_wr_en    = we;
    mif.id_mem_rd   = ld;
    mif.id_rs1_addr = rs1;
    mif.id_rs2_addr = rs2;
    mif.id_rs1_used = u1;
    mif.id_rs2_used = u2;
    mif.flush       = fl;
    cnt_clr         = clr;
    #1;
    s  = m_stall();
    st = mif.stall;
    chk({tag, ".stall"},     32'(mif.stall), 32'(s));
    chk({tag, ".stall_sat"}, 32'(sif.stall), 32'(s));
    @(posedge clk);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    if (fl || s) begin
      pipe[0] = '0;
    end else begin
      e.rd = rd;
      e.we = we && (rd != 5'd0);
      e.ld = ld;
      pipe[0] = e;
    end
    if (clr) begin
      m_cnt16 = 0;
      m_cnt2  = 0;
    end else if (s) begin
      m_cnt16 = (m_cnt16 == 65535) ? 65535 : m_cnt16 + 1;
      m_cnt2  = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    chk({tag, ".stall"}, 32'(mif.stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic st;
    mif.id_rd_addr  = '0;
    mif.id_wr_en    = 1'b0;
    mif.id_mem_rd   = 1'b0;
    mif.id_rs1_addr = '0;
    mif.id_rs2_addr = '0;
    mif.id_rs1_used = 1'b0;
    mif.id_rs2_used = 1'b0;
    mif.flush       = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset("reset");

    step("b2b0", 5'd3, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, st);
    step("b2b1", 5'd4, 1, 0, 5'd3, 5'd0, 1, 0, 0, 0, st);
    step("b2b2", 5'd5, 1, 0, 5'd4, 5'd3, 1, 1, 0, 0, st);
    chk("b2b.ex_rd",  32'(mif.ex_rd_addr),  32'd5);
    chk("b2b.mem_rd", 32'(mif.mem_rd_addr), 32'd4);
    chk("b2b.wb_rd",  32'(mif.wb_rd_addr),  32'd3);
    chk("b2b.wb_we",  32'(mif.wb_wr_en),    32'd1);

    step("fill0", 5'd5, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, st);
    step("fill1", 5'd5, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, st);
    step("fill2", 5'd5, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, st);
    #2;
    do_reset("midrst");
    chk("midrst.cnt", 32'(cnt16), 32'd0);

    step("lu_ld", 5'd7, 1, 1, 5'd0, 5'd0, 0, 0, 0, 0, st);
    step("lu_use", 5'd9, 1, 0, 5'd1, 5'd7, 0, 1, 0, 0, st);
    chk("lu.stall_hi", 32'(st), 32'd1);
    chk("lu.ex_we",    32'(mif.ex_wr_en),    32'd0);
    chk("lu.mem_rd",   32'(mif.mem_rd_addr), 32'd7);
    chk("lu.mem_we",   32'(mif.mem_wr_en),   32'd1);
    chk("lu.cnt",      32'(cnt16),           32'd1);
    step("lu_retry", 5'd9, 1, 0, 5'd1, 5'd7, 0, 1, 0, 0, st);
    chk("lu.stall_once", 32'(st), 32'd0);
    chk("lu.ex_rd",      32'(mif.ex_rd_addr), 32'd9);

    step("nouse_ld", 5'd7, 1, 1, 5'd0, 5'd0, 0, 0, 0, 0, st);
    step("nouse", 5'd2, 1, 0, 5'd7, 5'd0, 0, 0, 0, 0, st);
    chk("nouse.stall", 32'(st), 32'd0);
    step("x0_ld", 5'd0, 1, 1, 5'd0, 5'd0, 0, 0, 0, 0, st);
    chk("x0.ex_we", 32'(mif.ex_wr_en), 32'd0);
    step("x0_use", 5'd2, 1, 0, 5'd0, 5'd0, 1, 1, 0, 0, st);
    chk("x0.stall", 32'(st), 32'd0);

    step("fl_ld", 5'd7, 1, 1, 5'd0, 5'd0, 0, 0, 0, 0, st);
    step("fl_use", 5'd8, 1, 1, 5'd7, 5'd0, 1, 0, 1, 0, st);
    chk("fl.stall",  32'(st), 32'd0);
    chk("fl.ex_rd",  32'(mif.ex_rd_addr), 32'd0);
    chk("fl.ex_we",  32'(mif.ex_wr_en),   32'd0);
    chk("fl.ex_ld",  32'(mif.ex_mem_rd),  32'd0);
    chk("fl.cnt",    32'(cnt16),          32'd1);

    step("sat_clr", 5'd0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 1, st);
    for (int i = 0; i < 5; i++) begin
      step("sat_ld", 5'd7, 1, 1, 5'd0, 5'd0, 0, 0, 0, 0, st);
      step("sat_use", 5'd6, 1, 0, 5'd7, 5'd7, 1, 1, 0, 0, st);
    end
    chk("sat.cnt2",  32'(cnt2),  32'd3);
    chk("sat.cnt16", 32'(cnt16), 32'd5);
    step("clr_ld", 5'd7, 1, 1, 5'd0, 5'd0, 0, 0, 0, 0, st);
    step("clr_use", 5'd6, 1, 0, 5'd7, 5'd0, 1, 0, 0, 1, st);
    chk("clr.stall", 32'(st),    32'd1);
    chk("clr.cnt2",  32'(cnt2),  32'd0);
    chk("clr.cnt16", 32'(cnt16), 32'd0);

    for (int i = 0; i < 400; i++) begin
      step("rnd",
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 31) == 0), st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
